// File: rtl/hazard_mc.sv
// Hazard unit for a 5-stage pipeline: forwarding, load-use stall, branch flush, multi-cycle E stall.
// Define HAZARD_PERF_EN to add the PerfStall cycle counter output.
module hazard_mc #(
  parameter int REGW    = 5,
  parameter int LATW    = 4,
  parameter int ZERO_R0 = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [REGW-1:0] Rs1D,
  input  logic [REGW-1:0] Rs2D,
  input  logic [REGW-1:0] Rs1E,
  input  logic [REGW-1:0] Rs2E,
  input  logic [REGW-1:0] RdE,
  input  logic [REGW-1:0] RdM,
  input  logic [REGW-1:0] RdW,
  input  logic            RegWriteE,
  input  logic            RegWriteM,
  input  logic            RegWriteW,
  input  logic            LoadE,
  input  logic            BranchTakenE,
  input  logic            McStartE,
  input  logic [LATW-1:0] McLatE,
  output logic            StallF,
  output logic            StallD,
  output logic            StallE,
  output logic            FlushD,
  output logic            FlushE,
  output logic            BubbleM,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic            McBusy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]     PerfStall
`endif
);

  logic [LATW-1:0] mc_cnt_q, mc_cnt_d;
  logic            mc_busy;
  logic            mc_start;
  logic            mc_stall;
  logic            load_use;
  logic            e_writes;

  function automatic logic is_zero_reg(input logic [REGW-1:0] r);
    return (ZERO_R0 != 0) && (r == '0);
  endfunction

  function automatic logic [1:0] fwd_sel(
    input logic [REGW-1:0] rs,
    input logic            wr_m,
    input logic [REGW-1:0] rd_m,
    input logic            wr_w,
    input logic [REGW-1:0] rd_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (!is_zero_reg(rs)) begin
      if (wr_m && (rd_m == rs))      sel = 2'b10;
      else if (wr_w && (rd_w == rs)) sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
    ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
  end

  // A load always writes its destination, so LoadE implies the E-stage write.
  always_comb begin
    e_writes = RegWriteE | LoadE;
    load_use = LoadE && e_writes && !is_zero_reg(RdE) &&
               ((RdE == Rs1D) || (RdE == Rs2D));
  end

  // Counter holds remaining E-cycles minus one; the cycle at count 1 is the release cycle.
  always_comb begin
    mc_busy  = (mc_cnt_q != '0);
    mc_start = rst && McStartE && !mc_busy && (McLatE >= LATW'(2));
    mc_stall = mc_start || (mc_busy && (mc_cnt_q != LATW'(1)));
    mc_cnt_d = '0;
    if (mc_busy)       mc_cnt_d = mc_cnt_q - LATW'(1);
    else if (mc_start) mc_cnt_d = McLatE - LATW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mc_cnt_q <= '0;
    else      mc_cnt_q <= mc_cnt_d;
  end

  always_comb begin
    StallF  = mc_stall || load_use;
    StallD  = mc_stall || load_use;
    StallE  = mc_stall;
    BubbleM = mc_stall;
    FlushD  = BranchTakenE;
    FlushE  = !mc_stall && (load_use || BranchTakenE);
    McBusy  = mc_busy;
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (StallF) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) perf_q <= '0;
    else      perf_q <= perf_d;
  end

  assign PerfStall = perf_q;
`endif

endmodule

// File: tb/tb_hazard_mc.sv
// Self-checking bench for hazard_mc: directed cases then randomized traffic vs. a cycle-index model.
module tb_hazard_mc;
  localparam int REGW = 5;
  localparam int LATW = 4;

  logic clk = 1'b0;
  logic rst;
  logic [REGW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteE, RegWriteM, RegWriteW, LoadE, BranchTakenE, McStartE;
  logic [LATW-1:0] McLatE;

  logic StallF, StallD, StallE, FlushD, FlushE, BubbleM, McBusy;
  logic [1:0] ForwardAE, ForwardBE;
  logic z_StallF, z_StallD, z_StallE, z_FlushD, z_FlushE, z_BubbleM, z_McBusy;
  logic [1:0] z_ForwardAE, z_ForwardBE;
`ifdef HAZARD_PERF_EN
  logic [31:0] PerfStall, z_PerfStall;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_mc #(.REGW(REGW), .LATW(LATW), .ZERO_R0(1)) dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .LoadE(LoadE), .BranchTakenE(BranchTakenE),
    .McStartE(McStartE), .McLatE(McLatE), .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE), .BubbleM(BubbleM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .McBusy(McBusy)
`ifdef HAZARD_PERF_EN
    , .PerfStall(PerfStall)
`endif
  );

  hazard_mc #(.REGW(REGW), .LATW(LATW), .ZERO_R0(0)) dut_r0 (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .LoadE(LoadE), .BranchTakenE(BranchTakenE),
    .McStartE(McStartE), .McLatE(McLatE), .StallF(z_StallF), .StallD(z_StallD),
    .StallE(z_StallE), .FlushD(z_FlushD), .FlushE(z_FlushE), .BubbleM(z_BubbleM),
    .ForwardAE(z_ForwardAE), .ForwardBE(z_ForwardBE), .McBusy(z_McBusy)
`ifdef HAZARD_PERF_EN
    , .PerfStall(z_PerfStall)
`endif
  );

  // Reference model: a multi-cycle op is remembered as (start cycle, latency).
  int  cyc = 0;
  bit  mActive = 0;
  int  mStart = 0;
  int  mLat = 0;
  int  perfExp = 0;

  function automatic bit modelBusy();
    return mActive && (cyc > mStart) && (cyc <= mStart + mLat - 1);
  endfunction

  function automatic bit modelStartNow();
    return rst && McStartE && !modelBusy() && (int'(McLatE) >= 2);
  endfunction

  function automatic bit modelMcStall();
    if (modelStartNow()) return 1'b1;
    return mActive && (cyc >= mStart) && (cyc < mStart + mLat - 1);
  endfunction

  function automatic bit modelLoadUse(input bit zeroR0);
    if (!LoadE) return 1'b0;
    if (zeroR0 && RdE == 0) return 1'b0;
    return (RdE == Rs1D) || (RdE == Rs2D);
  endfunction

  function automatic logic [1:0] modelFwd(input logic [REGW-1:0] rs, input bit zeroR0);
    if (zeroR0 && rs == 0) return 2'b00;
    if (RegWriteM && RdM == rs) return 2'b10;
    if (RegWriteW && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mActive = 1'b0;
      perfExp = 0;
    end else begin
      if (modelMcStall() || modelLoadUse(1'b1)) perfExp = perfExp + 1;
      if (modelStartNow()) begin
        mActive = 1'b1;
        mStart  = cyc;
        mLat    = int'(McLatE);
      end
      cyc = cyc + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    bit mcs, lu, lu0;
    mcs = modelMcStall();
    lu  = modelLoadUse(1'b1);
    lu0 = modelLoadUse(1'b0);
    checkOutput({tag, ".FwdA"},   32'(ForwardAE), 32'(modelFwd(Rs1E, 1'b1)));
    checkOutput({tag, ".FwdB"},   32'(ForwardBE), 32'(modelFwd(Rs2E, 1'b1)));
    checkOutput({tag, ".StallF"}, 32'(StallF),  32'(mcs || lu));
    checkOutput({tag, ".StallD"}, 32'(StallD),  32'(mcs || lu));
    checkOutput({tag, ".StallE"}, 32'(StallE),  32'(mcs));
    checkOutput({tag, ".Bubble"}, 32'(BubbleM), 32'(mcs));
    checkOutput({tag, ".FlushD"}, 32'(FlushD),  32'(BranchTakenE));
    checkOutput({tag, ".FlushE"}, 32'(FlushE),  32'(!mcs && (lu || BranchTakenE)));
    checkOutput({tag, ".McBusy"}, 32'(McBusy),  32'(modelBusy()));
    checkOutput({tag, ".r0FwdA"}, 32'(z_ForwardAE), 32'(modelFwd(Rs1E, 1'b0)));
    checkOutput({tag, ".r0FwdB"}, 32'(z_ForwardBE), 32'(modelFwd(Rs2E, 1'b0)));
    checkOutput({tag, ".r0StallF"}, 32'(z_StallF), 32'(mcs || lu0));
`ifdef HAZARD_PERF_EN
    checkOutput({tag, ".Perf"}, PerfStall, 32'(perfExp));
`endif
  endtask

  task automatic clearInputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteE, RegWriteM, RegWriteW, LoadE, BranchTakenE, McStartE} = '0;
    McLatE = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    Rs1D = REGW'($urandom_range(0, 3));
    Rs2D = REGW'($urandom_range(0, 3));
    Rs1E = REGW'($urandom_range(0, 3));
    Rs2E = REGW'($urandom_range(0, 3));
    RdE  = REGW'($urandom_range(0, 3));
    RdM  = REGW'($urandom_range(0, 3));
    RdW  = REGW'($urandom_range(0, 3));
    RegWriteE    = 1'($urandom_range(0, 1));
    RegWriteM    = 1'($urandom_range(0, 1));
    RegWriteW    = 1'($urandom_range(0, 1));
    LoadE        = 1'($urandom_range(0, 1));
    BranchTakenE = ($urandom_range(0, 4) == 0);
    McStartE     = ($urandom_range(0, 2) == 0);
    McLatE       = LATW'($urandom_range(0, 7));
  endtask

  initial begin
`ifdef HAZARD_PERF_EN
    logic [31:0] perfBefore;
`endif
    clearInputs();
    rst = 1'b0;
    #12;
    checkOutput("rst.StallF", 32'(StallF), 32'd0);
    checkOutput("rst.FlushE", 32'(FlushE), 32'd0);
    checkOutput("rst.McBusy", 32'(McBusy), 32'd0);
    checkOutput("rst.FwdA",   32'(ForwardAE), 32'd0);
    checkAll("rst");
    rst = 1'b1;
    tick();

    RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5;
    #2 checkOutput("fwd.MoverW", 32'(ForwardAE), 32'b10);
    RegWriteM = 0;
    #1 checkOutput("fwd.W", 32'(ForwardAE), 32'b01);
    clearInputs();
    RegWriteM = 1; RdM = 0; Rs1E = 0;
    #1 checkOutput("fwd.r0hard", 32'(ForwardAE), 32'b00);
    checkOutput("fwd.r0real", 32'(z_ForwardAE), 32'b10);
    tick();

    clearInputs();
    LoadE = 1; RdE = 3; Rs2D = 3;
    #2 checkOutput("lu.StallF", 32'(StallF), 32'd1);
    checkOutput("lu.StallD", 32'(StallD), 32'd1);
    checkOutput("lu.FlushE", 32'(FlushE), 32'd1);
    checkOutput("lu.StallE", 32'(StallE), 32'd0);
    tick();
    LoadE = 0;
    #2 checkOutput("lu.after", 32'(StallF), 32'd0);
    checkAll("lu");

    clearInputs();
    tick();
`ifdef HAZARD_PERF_EN
    perfBefore = PerfStall;
`endif
    McStartE = 1; McLatE = 4;
    for (int i = 0; i < 4; i++) begin
      #2 checkOutput("mc4.StallF", 32'(StallF), 32'(i < 3));
      checkOutput("mc4.Bubble", 32'(BubbleM), 32'(i < 3));
      checkOutput("mc4.McBusy", 32'(McBusy), 32'(i >= 1));
      checkAll("mc4");
      tick();
    end
    McStartE = 0;
    #2 checkOutput("mc4.done", 32'(McBusy), 32'd0);
`ifdef HAZARD_PERF_EN
    checkOutput("mc4.perf", PerfStall - perfBefore, 32'd3);
`endif

    McStartE = 1; McLatE = 3;
    tick();
    McStartE = 0; LoadE = 1; RdE = 2; Rs1D = 2;
    #2 checkOutput("prio.FlushE", 32'(FlushE), 32'd0);
    checkOutput("prio.StallE", 32'(StallE), 32'd1);
    checkAll("prio");
    tick();
    clearInputs();
    tick();

    McStartE = 1; McLatE = 6;
    tick(); tick(); tick();
    McStartE = 0;
    rst = 1'b0;
    #1 checkOutput("abort.McBusy", 32'(McBusy), 32'd0);
    checkOutput("abort.StallF", 32'(StallF), 32'd0);
    checkOutput("abort.Bubble", 32'(BubbleM), 32'd0);
    #3 rst = 1'b1;
    tick();
    McStartE = 1; McLatE = 1;
    #2 checkOutput("lat1.StallF", 32'(StallF), 32'd0);
    tick();
    McStartE = 0;
    #2 checkOutput("lat1.McBusy", 32'(McBusy), 32'd0);

    BranchTakenE = 1; LoadE = 1; RdE = 7; Rs1D = 7;
    #1 checkOutput("br.FlushD", 32'(FlushD), 32'd1);
    checkOutput("br.FlushE", 32'(FlushE), 32'd1);
    checkAll("br");
    tick();

    for (int i = 0; i < 300; i++) begin
      applyStimulus();
      #2 checkAll("rnd");
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end
endmodule
